// File: rtl/timer_pkg.sv
// Shared constants and types for the 8051 timer control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    localparam logic [7:0] TCON_ADDR = 8'h88;
    localparam logic [7:0] TMOD_ADDR = 8'h89;

    localparam int TF1 = 7;
    localparam int TR1 = 6;
    localparam int TF0 = 5;
    localparam int TR0 = 4;

    localparam int GATE = 3;
    localparam int CT   = 2;
    localparam int M1   = 1;
    localparam int M0   = 0;

    localparam int PRESCALE_DEF    = 12;
    localparam int SYNC_STAGES_DEF = 2;

    typedef struct packed {
        logic       gate;
        logic       ct;
        logic [1:0] mode;
    } tmode_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Synchronises one asynchronous pin and flags its falling edges.
// Latency: level valid SYNC_STAGES clocks after the pin; fall is combinational on level.
// Backpressure: none.
module pin_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 1 so an idle-high pin never produces a spurious fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = prev_q & ~level;

endmodule

// File: rtl/timer_ctrl.sv
// TCON/TMOD ownership, prescaler, run qualification and tick generation for T0/T1.
// Latency: ticks registered one clock after their source; SFR writes visible next cycle.
// Backpressure: none; overflow pulses and acks are always accepted.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRESCALE    = PRESCALE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_wr,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] sfr_rdata,
    input  logic       t0_pin,
    input  logic       t1_pin,
    input  logic       int0_n,
    input  logic       int1_n,
    input  logic       t0_ovf,
    input  logic       t1_ovf,
    output logic       t0_tick,
    output logic       t1_tick,
    output logic [3:0] t0_mode,
    output logic [3:0] t1_mode,
    output logic [3:0] tcon_low,
    output logic       irq_t0,
    output logic       irq_t1,
    input  logic [1:0] irq_ack
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;
    logic          mc_pulse;
    logic [7:0]    tcon_q, tcon_d;
    logic [7:0]    tmod_q;
    tmode_t        t0_m, t1_m;
    logic          t0_lvl_unused, t1_lvl_unused;
    logic          int0_fall_unused, int1_fall_unused;
    logic          t0_fall, t1_fall, int0_lvl, int1_lvl;
    logic          run0, run1, src0, src1, t1_halt;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_t0 (
        .clk(clk), .rst(rst), .pin(t0_pin), .level(t0_lvl_unused), .fall(t0_fall));
    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_t1 (
        .clk(clk), .rst(rst), .pin(t1_pin), .level(t1_lvl_unused), .fall(t1_fall));
    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_int0 (
        .clk(clk), .rst(rst), .pin(int0_n), .level(int0_lvl), .fall(int0_fall_unused));
    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_int1 (
        .clk(clk), .rst(rst), .pin(int1_n), .level(int1_lvl), .fall(int1_fall_unused));

    assign mc_pulse = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= mc_pulse ? '0 : pre_q + 1'b1;
        end
    end

    // Later assignments win: overflow beats ack, ack beats a software write.
    always_comb begin
        tcon_d = tcon_q;
        if (sfr_wr && (sfr_addr == TCON_ADDR)) tcon_d = sfr_wdata;
        if (irq_ack[0]) tcon_d[TF0] = 1'b0;
        if (irq_ack[1]) tcon_d[TF1] = 1'b0;
        if (t0_ovf)     tcon_d[TF0] = 1'b1;
        if (t1_ovf)     tcon_d[TF1] = 1'b1;
    end

    assign t0_m    = tmode_t'(tmod_q[3:0]);
    assign t1_m    = tmode_t'(tmod_q[7:4]);
    assign run0    = tcon_q[TR0] & (~t0_m.gate | int0_lvl);
    assign run1    = tcon_q[TR1] & (~t1_m.gate | int1_lvl);
    assign src0    = t0_m.ct ? t0_fall : mc_pulse;
    assign src1    = t1_m.ct ? t1_fall : mc_pulse;
    assign t1_halt = (t1_m.mode == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            tcon_q  <= 8'h00;
            tmod_q  <= 8'h00;
            t0_tick <= 1'b0;
            t1_tick <= 1'b0;
        end else begin
            tcon_q  <= tcon_d;
            if (sfr_wr && (sfr_addr == TMOD_ADDR)) tmod_q <= sfr_wdata;
            t0_tick <= run0 & src0;
            t1_tick <= run1 & src1 & ~t1_halt;
        end
    end

    always_comb begin
        sfr_rdata = 8'h00;
        case (sfr_addr)
            TCON_ADDR: sfr_rdata = tcon_q;
            TMOD_ADDR: sfr_rdata = tmod_q;
            default:   sfr_rdata = 8'h00;
        endcase
    end

    assign t0_mode  = tmod_q[3:0];
    assign t1_mode  = tmod_q[7:4];
    assign tcon_low = tcon_q[3:0];
    assign irq_t0   = tcon_q[TF0];
    assign irq_t1   = tcon_q[TF1];

endmodule
